// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU types, flag bit indices, write-back states and bus address width.
package alu_pkg;
    localparam int ADDR_W = 24;
    typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_MOV} AluOp;
    typedef enum logic [1:0] {ALU_FLAG_Z = 2'd0, ALU_FLAG_C = 2'd1, ALU_FLAG_V = 2'd2, ALU_FLAG_S = 2'd3} AluFlags;
    typedef enum logic [1:0] {IDLE, MEM_LO, MEM_HI, FINISH} WbState;
endpackage

// File: rtl/alu_result_writer_if.sv
// alu_result_writer_if: ALU result handshake, regfile write port, byte bus and status of the write-back stage.
interface alu_result_writer_if;
    import alu_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_result;
    logic [3:0]        in_flags;
    logic [3:0]        in_flag_mask;
    logic              in_size;
    logic              in_to_mem;
    logic [2:0]        in_reg_sel;
    logic [ADDR_W-1:0] in_addr;
    logic              reg_we;
    logic [2:0]        reg_sel;
    logic [15:0]       reg_wdata;
    logic              reg_wsize;
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_ack;
    logic [3:0]        sc_flags;
    logic              done;
    logic              bus_err;
    modport master (
        output in_valid, in_result, in_flags, in_flag_mask, in_size, in_to_mem, in_reg_sel, in_addr, bus_ack,
        input  in_ready, reg_we, reg_sel, reg_wdata, reg_wsize, bus_req, bus_addr, bus_wdata, sc_flags, done, bus_err
    );
    modport slave (
        input  in_valid, in_result, in_flags, in_flag_mask, in_size, in_to_mem, in_reg_sel, in_addr, bus_ack,
        output in_ready, reg_we, reg_sel, reg_wdata, reg_wsize, bus_req, bus_addr, bus_wdata, sc_flags, done, bus_err
    );
endinterface

// File: rtl/alu_result_writer.sv
// alu_result_writer: commits ALU results to the regfile or to memory as 1-2 bus bytes and updates SC flags.
// Define ALU_WB_TIMEOUT_EN to add a per-byte bus_ack timeout that sets sticky bus_err.
module alu_result_writer
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic clk,
    input logic reset,
    alu_result_writer_if.slave wb
);
    WbState     state;
    logic       size_q;
    logic [7:0] r_hi;
`ifdef ALU_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            size_q       <= 1'b0;
            r_hi         <= 8'h00;
            wb.in_ready  <= 1'b1;
            wb.reg_we    <= 1'b0;
            wb.reg_sel   <= 3'd0;
            wb.reg_wdata <= 16'h0000;
            wb.reg_wsize <= 1'b0;
            wb.bus_req   <= 1'b0;
            wb.bus_addr  <= '0;
            wb.bus_wdata <= 8'h00;
            wb.sc_flags  <= 4'h0;
            wb.done      <= 1'b0;
            wb.bus_err   <= 1'b0;
`ifdef ALU_WB_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            wb.reg_we <= 1'b0;
            wb.done   <= 1'b0;
            case (state)
                IDLE: begin
`ifdef ALU_WB_TIMEOUT_EN
                    cnt <= '0;
`endif
                    if (wb.in_valid && wb.in_ready) begin
                        wb.sc_flags <= (wb.sc_flags & ~wb.in_flag_mask) | (wb.in_flags & wb.in_flag_mask);
                        wb.in_ready <= 1'b0;
                        size_q      <= wb.in_size;
                        r_hi        <= wb.in_result[15:8];
                        if (wb.in_to_mem) begin
                            state        <= MEM_LO;
                            wb.bus_req   <= 1'b1;
                            wb.bus_addr  <= wb.in_addr;
                            wb.bus_wdata <= wb.in_result[7:0];
                        end else begin
                            state        <= FINISH;
                            wb.reg_we    <= 1'b1;
                            wb.reg_sel   <= wb.in_reg_sel;
                            wb.reg_wdata <= wb.in_size ? wb.in_result : {8'h00, wb.in_result[7:0]};
                            wb.reg_wsize <= wb.in_size;
                        end
                    end
                end
                MEM_LO, MEM_HI: begin
                    if (wb.bus_ack) begin
`ifdef ALU_WB_TIMEOUT_EN
                        cnt <= '0;
`endif
                        // High byte follows immediately; bus_req stays asserted across the hand-over
                        if (state == MEM_LO && size_q) begin
                            state        <= MEM_HI;
                            wb.bus_addr  <= wb.bus_addr + 1'b1;
                            wb.bus_wdata <= r_hi;
                        end else begin
                            state      <= FINISH;
                            wb.bus_req <= 1'b0;
                        end
                    end
`ifdef ALU_WB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state      <= FINISH;
                        wb.bus_req <= 1'b0;
                        wb.bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                FINISH: begin
                    state       <= IDLE;
                    wb.done     <= 1'b1;
                    wb.in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
